// File: rtl/noc_local_port_arbiter.sv
// noc_local_port_arbiter
// Packet-level round-robin arbiter that shares one router local port among NUMBERPENOC
// PEs. One requester owns the port from header through the last payload flit. Flits are
// forwarded combinationally over the credit handshake, so the arbiter adds no latency.
//
// Ports:
//   rel          clock (rising edge)
//   reset        asynchronous active-low reset
//   tx_req       per-requester flit valid
//   data_req     per-requester flit data
//   credit_req   per-requester credit (only the granted bit can be 1)
//   tx_o/data_o  flit valid/data to the router local port
//   credit_i     router local-port credit
//   grant        one-hot current owner, zero when idle
//   busy         packet in flight
//   service_o    first payload flit of the last forwarded packet
//   service_vld  one-cycle pulse when service_o updates
module noc_local_port_arbiter #(
    parameter int NUMBERPENOC = 4,
    parameter int TAM_FLIT    = 16
) (
    input  logic                                 rel,
    input  logic                                 reset,
    input  logic [NUMBERPENOC-1:0]               tx_req,
    input  logic [NUMBERPENOC-1:0][TAM_FLIT-1:0] data_req,
    output logic [NUMBERPENOC-1:0]               credit_req,
    output logic                                 tx_o,
    output logic [TAM_FLIT-1:0]                  data_o,
    input  logic                                 credit_i,
    output logic [NUMBERPENOC-1:0]               grant,
    output logic                                 busy,
    output logic [TAM_FLIT-1:0]                  service_o,
    output logic                                 service_vld
);

    localparam int IdxW = (NUMBERPENOC > 1) ? $clog2(NUMBERPENOC) : 1;

    typedef enum logic [1:0] {StIdle, StHeader, StSize, StPayload} state_e;

    state_e                 state_q, state_d;
    logic [NUMBERPENOC-1:0] grant_q, grant_d;
    logic [IdxW-1:0]        last_q, last_d;
    logic [TAM_FLIT-1:0]    remaining_q, remaining_d;
    logic [TAM_FLIT-1:0]    service_q, service_d;
    logic                   first_q, first_d;
    logic                   service_vld_q, service_vld_d;

    logic                   xfer;
    logic                   pick_vld;
    logic [IdxW-1:0]        pick_idx;

    // Forward the granted requester; grant_q is zero in idle, so everything reads zero.
    always_comb begin
        tx_o       = 1'b0;
        data_o     = '0;
        credit_req = '0;
        for (int i = 0; i < NUMBERPENOC; i++) begin
            if (grant_q[i]) begin
                tx_o          = tx_req[i];
                data_o        = data_req[i];
                credit_req[i] = credit_i;
            end
        end
    end

    assign xfer = tx_o & credit_i;

    // Round-robin pick: first set request scanning upward from last+1 with wrap.
    always_comb begin : rr_pick
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= NUMBERPENOC; k++) begin
            idx = (int'(last_q) + k) % NUMBERPENOC;
            if (!pick_vld && tx_req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = IdxW'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        remaining_d   = remaining_q;
        service_d     = service_q;
        first_d       = first_q;
        service_vld_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    last_d            = pick_idx;
                    state_d           = StHeader;
                end
            end
            StHeader: begin
                if (xfer) state_d = StSize;
            end
            StSize: begin
                if (xfer) begin
                    remaining_d = data_o;
                    if (data_o == '0) begin
                        state_d = StIdle;
                        grant_d = '0;
                    end else begin
                        state_d = StPayload;
                        first_d = 1'b1;
                    end
                end
            end
            StPayload: begin
                if (xfer) begin
                    remaining_d = remaining_q - TAM_FLIT'(1);
                    if (first_q) begin
                        service_d     = data_o;
                        service_vld_d = 1'b1;
                        first_d       = 1'b0;
                    end
                    if (remaining_q == TAM_FLIT'(1)) begin
                        state_d = StIdle;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge rel or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            last_q        <= IdxW'(NUMBERPENOC - 1);
            remaining_q   <= '0;
            service_q     <= '0;
            first_q       <= 1'b0;
            service_vld_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_q        <= last_d;
            remaining_q   <= remaining_d;
            service_q     <= service_d;
            first_q       <= first_d;
            service_vld_q <= service_vld_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q != StIdle);
    assign service_o   = service_q;
    assign service_vld = service_vld_q;

endmodule

// File: tb/tb_noc_local_port_arbiter.sv
// Bench for noc_local_port_arbiter: per-requester flit sources fed from queues, a
// packet-level reference model, a per-cycle compare process, and directed scenarios
// with literal expectations.
`timescale 1ns/1ps
module tb_noc_local_port_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic               rel      = 1'b0;
    logic               reset    = 1'b1;
    logic [N-1:0]       tx_req   = '0;
    logic [N-1:0][W-1:0] data_req = '0;
    logic [N-1:0]       credit_req;
    logic               tx_o;
    logic [W-1:0]       data_o;
    logic               credit_i = 1'b1;
    logic [N-1:0]       grant;
    logic               busy;
    logic [W-1:0]       service_o;
    logic               service_vld;

    noc_local_port_arbiter #(
        .NUMBERPENOC (N),
        .TAM_FLIT    (W)
    ) dut (
        .rel         (rel),
        .reset       (reset),
        .tx_req      (tx_req),
        .data_req    (data_req),
        .credit_req  (credit_req),
        .tx_o        (tx_o),
        .data_o      (data_o),
        .credit_i    (credit_i),
        .grant       (grant),
        .busy        (busy),
        .service_o   (service_o),
        .service_vld (service_vld)
    );

    always #5 rel = ~rel;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    logic [W-1:0] q [N][$];
    bit   [N-1:0] pause     = '0;
    bit   [N-1:0] xfer_seen = '0;
    logic [W-1:0] xlog [$];
    int           gseq [$];
    int           svld_cnt   = 0;
    logic [N-1:0] prev_grant = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- sources: inputs change only 2 ns after the rising edge
    always @(negedge rel) begin
        for (int i = 0; i < N; i++) xfer_seen[i] = tx_req[i] & credit_req[i];
    end

    always @(posedge rel) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (xfer_seen[i] && q[i].size() > 0) void'(q[i].pop_front());
            if (q[i].size() > 0 && !pause[i]) begin
                tx_req[i]   = 1'b1;
                data_req[i] = q[i][0];
            end else begin
                tx_req[i]   = 1'b0;
                data_req[i] = '0;
            end
        end
    end

    // ---------------- packet-level reference model
    int           m_owner   = -1;
    int           m_last    = N - 1;
    int           m_cnt     = 0;
    int           m_size    = 0;
    logic [W-1:0] m_service = '0;
    bit           m_svld    = 1'b0;

    always @(posedge rel or negedge reset) begin
        if (!reset) begin
            m_owner   <= -1;
            m_last    <= N - 1;
            m_cnt     <= 0;
            m_size    <= 0;
            m_service <= '0;
            m_svld    <= 1'b0;
        end else begin
            m_svld <= 1'b0;
            if (m_owner < 0) begin
                if (tx_req != '0) begin
                    m_owner <= rr_pick(m_last, tx_req);
                    m_last  <= rr_pick(m_last, tx_req);
                    m_cnt   <= 0;
                end
            end else if (tx_req[m_owner] && credit_i) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 1) begin
                    m_size <= int'(data_req[m_owner]);
                    if (data_req[m_owner] == '0) m_owner <= -1;
                end else if (m_cnt >= 2) begin
                    if (m_cnt == 2) begin
                        m_service <= data_req[m_owner];
                        m_svld    <= 1'b1;
                    end
                    if (m_cnt + 1 == m_size + 2) m_owner <= -1;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model
    logic [N-1:0] e_grant, e_credit;
    logic         e_tx;
    logic [W-1:0] e_data;

    always @(negedge rel) begin
        if (cmp_en) begin
            e_grant  = '0;
            e_credit = '0;
            e_tx     = 1'b0;
            e_data   = '0;
            if (m_owner >= 0) begin
                e_grant[m_owner]  = 1'b1;
                e_credit[m_owner] = credit_i;
                e_tx              = tx_req[m_owner];
                e_data            = data_req[m_owner];
            end
            chk("cmp_grant", grant, e_grant);
            chk("cmp_busy", busy, m_owner >= 0);
            chk("cmp_tx_o", tx_o, e_tx);
            chk("cmp_data_o", data_o, e_data);
            chk("cmp_credit_req", credit_req, e_credit);
            chk("cmp_service_o", service_o, m_service);
            chk("cmp_service_vld", service_vld, m_svld);
        end
    end

    // ---------------- transfer / grant / service monitors
    always @(negedge rel) begin
        if (cmp_en) begin
            if (tx_o && credit_i) xlog.push_back(data_o);
            if (service_vld) svld_cnt++;
            if (grant != '0 && prev_grant == '0) gseq.push_back(onehot_idx(grant));
            prev_grant = grant;
        end
    end

    // ---------------- helpers
    task automatic nedge();
        @(negedge rel);
        #1;
    endtask

    task automatic pedge();
        @(posedge rel);
        #1;
    endtask

    task automatic push_pkt(input int r, input logic [W-1:0] hdr, input int size,
                            input logic [W-1:0] base);
        q[r].push_back(hdr);
        q[r].push_back(W'(size));
        for (int k = 0; k < size; k++) q[r].push_back(base + W'(k));
    endtask

    task automatic wait_done(input string name, input int budget);
        int t;
        t = 0;
        nedge();
        while ((busy || !all_empty()) && t < budget) begin
            nedge();
            t++;
        end
        chk(name, t < budget, 1);
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        int t;
        t = 0;
        while (xlog.size() < n && t < budget) begin
            nedge();
            t++;
        end
        chk(name, t < budget, 1);
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) q[i].delete();
        xfer_seen = '0;
        pause     = '0;
    endtask

    task automatic do_reset();
        @(posedge rel);
        #3 reset = 1'b0;
        clear_sources();
        repeat (2) @(posedge rel);
        #3 reset = 1'b1;
        xlog.delete();
        gseq.delete();
        svld_cnt = 0;
    endtask

    logic [W-1:0] exp_single [5] = '{16'h0101, 16'h0003, 16'h0020, 16'hAAAA, 16'hBBBB};
    logic [W-1:0] exp_bp [10] = '{16'h1100, 16'h0004, 16'h0B00, 16'h0B01, 16'h0B02,
                                  16'h0B03, 16'h3300, 16'h0002, 16'h0D00, 16'h0D01};
    logic [W-1:0] exp_stall [9] = '{16'h2200, 16'h0004, 16'h0E00, 16'h0E01, 16'h0E02,
                                    16'h0E03, 16'h0F00, 16'h0001, 16'h0F10};
    logic [W-1:0] exp_rst [4] = '{16'h1A00, 16'h0002, 16'h0A10, 16'h0A11};
    bit           pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int t;
        int c;

        // Reset values
        #2 reset = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_o", tx_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_credit_req", credit_req, 0);
        chk("rst_service_o", service_o, 0);
        chk("rst_service_vld", service_vld, 0);
        repeat (2) @(posedge rel);
        #3 reset = 1'b1;

        // Single packet from requester 2
        pedge();
        q[2].push_back(16'h0101);
        q[2].push_back(16'h0003);
        q[2].push_back(16'h0020);
        q[2].push_back(16'hAAAA);
        q[2].push_back(16'hBBBB);
        nedge();
        chk("t1_no_grant_yet", grant, 0);
        t = 0;
        while (grant == '0 && t < 20) begin
            nedge();
            t++;
        end
        chk("t1_grant", grant, 4'b0100);
        for (int j = 0; j < 5; j++) begin
            chk("t1_data_o", data_o, exp_single[j]);
            chk("t1_tx_o", tx_o, 1);
            if (j == 3) begin
                chk("t1_service_vld", service_vld, 1);
                chk("t1_service_o", service_o, 16'h0020);
            end
            nedge();
        end
        chk("t1_busy_released", busy, 0);
        chk("t1_grant_released", grant, 0);
        chk("t1_svld_count", svld_cnt, 1);

        // Round-robin fairness
        do_reset();
        pedge();
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < N; r++) begin
                push_pkt(r, W'(16'h1000 + r * 16'h0100 + p), 3, W'(16'h0500 + r * 16'h10));
            end
        end
        wait_done("t2_timeout", 400);
        chk("t2_grant_count", gseq.size(), 8);
        for (int i = 0; i < gseq.size() && i < 8; i++) chk("t2_grant_order", gseq[i], i % 4);
        chk("t2_flit_count", xlog.size(), 40);

        // Backpressure on credit_i
        do_reset();
        pedge();
        push_pkt(1, 16'h1100, 4, 16'h0B00);
        push_pkt(3, 16'h3300, 2, 16'h0D00);
        c = 0;
        while (!(all_empty() && !busy && c > 2) && c < 200) begin
            pedge();
            credit_i = pat[c % 4];
            c++;
        end
        credit_i = 1'b1;
        chk("t3_timeout", c < 200, 1);
        chk("t3_flit_count", xlog.size(), 10);
        for (int i = 0; i < xlog.size() && i < 10; i++) chk("t3_flit_order", xlog[i], exp_bp[i]);

        // Boundary sizes
        do_reset();
        pedge();
        q[0].push_back(16'h0A00);
        q[0].push_back(16'h0000);
        wait_done("t4a_timeout", 50);
        chk("t4a_flit_count", xlog.size(), 2);
        chk("t4a_no_service", svld_cnt, 0);
        chk("t4a_grant_released", grant, 0);
        pedge();
        push_pkt(2, 16'h0C00, 1, 16'h0070);
        wait_done("t4b_timeout", 50);
        chk("t4b_flit_count", xlog.size(), 5);
        chk("t4b_service_o", service_o, 16'h0070);
        chk("t4b_svld_count", svld_cnt, 1);

        // Requester stall mid-payload
        do_reset();
        pedge();
        push_pkt(2, 16'h2200, 4, 16'h0E00);
        wait_log("t5_reach_payload", 4, 50);
        pedge();
        pause[2] = 1'b1;
        push_pkt(0, 16'h0F00, 1, 16'h0F10);
        for (int k = 0; k < 10; k++) begin
            nedge();
            chk("t5_grant_held", grant, 4'b0100);
            chk("t5_tx_o_low", tx_o, 0);
            chk("t5_other_credit", credit_req[0], 0);
            chk("t5_busy", busy, 1);
        end
        pedge();
        pause[2] = 1'b0;
        wait_done("t5_timeout", 100);
        chk("t5_flit_count", xlog.size(), 9);
        for (int i = 0; i < xlog.size() && i < 9; i++) chk("t5_flit_order", xlog[i], exp_stall[i]);

        // Asynchronous reset mid-packet
        do_reset();
        pedge();
        push_pkt(3, 16'h3300, 5, 16'h0900);
        wait_log("t6_reach_payload", 3, 50);
        @(posedge rel);
        #3 reset = 1'b0;
        clear_sources();
        #1;
        chk("t6_tx_o", tx_o, 0);
        chk("t6_grant", grant, 0);
        chk("t6_busy", busy, 0);
        chk("t6_credit_req", credit_req, 0);
        repeat (2) @(posedge rel);
        #3 reset = 1'b1;
        xlog.delete();
        gseq.delete();
        push_pkt(1, 16'h1A00, 2, 16'h0A10);
        t = 0;
        while (grant == '0 && t < 20) begin
            nedge();
            t++;
        end
        chk("t6_new_grant", grant, 4'b0010);
        wait_done("t6_timeout", 50);
        chk("t6_flit_count", xlog.size(), 4);
        for (int i = 0; i < xlog.size() && i < 4; i++) chk("t6_flit_order", xlog[i], exp_rst[i]);

        repeat (2) nedge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/noc_local_port_arbiter.md
# noc_local_port_arbiter

Packet-level round-robin arbiter that shares one NoC router local port among NUMBERPENOC requesting Plasma PEs in the hybrid bus/NoC cluster. It grants one requester at a time and forwards its complete HeMPS packet (header, size, payload) flit-by-flit over the credit-based local-port handshake. It then releases the port. It also captures the service code of each forwarded packet for the log monitors.

## Interface

Parameters:
- NUMBERPENOC, 4, number of requesters; index 0 is a valid requester
- TAM_FLIT, 16, flit width in bits (regflit)

Ports:
- rel  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- tx_req  in  NUMBERPENOC  per-requester flit valid
- data_req  in  NUMBERPENOC x TAM_FLIT  per-requester flit data
- credit_req  out  NUMBERPENOC  per-requester credit; only the granted bit may be 1
- tx_o  out  1  flit valid to router local port
- data_o  out  TAM_FLIT  flit data to router local port
- credit_i  in  1  router local-port credit
- grant  out  NUMBERPENOC  one-hot current owner; all-zero when idle
- busy  out  1  1 while a packet is in flight (state != IDLE)
- service_o  out  TAM_FLIT  service flit (first payload flit) of the last forwarded packet
- service_vld  out  1  one-cycle pulse when service_o updates

## Operation

- Transfer occurs on a rising edge where tx_o=1 and credit_i=1.
- Datapath is combinational from the granted requester:
  - tx_o = tx_req[g]
  - data_o = data_req[g]
  - credit_req[g] = credit_i
  - Other credit_req bits are 0.
  - In IDLE: tx_o=0, data_o=0, credit_req=0.
- FSM states: IDLE, HEADER, SIZE, PAYLOAD.
- IDLE:
  - If any tx_req bit is set, pick the first set bit scanning from (last+1) mod NUMBERPENOC upward with wrap.
  - Register that bit into grant and set last=g. Go to HEADER.
  - With no request, stay in IDLE.
- HEADER: on transfer, go to SIZE.
- SIZE: on transfer, load remaining <= data_o (TAM_FLIT-bit unsigned).
  - If data_o==0, go to IDLE and clear grant.
  - Otherwise go to PAYLOAD and set first=1.
- PAYLOAD: on each transfer, remaining <= remaining-1.
  - If first=1: service_o <= data_o, pulse service_vld, clear first.
  - If remaining==1 on the transfer, go to IDLE and clear grant.
- A requester deasserting tx_req mid-packet stalls the arbiter: it holds grant indefinitely and has no timeout. Other requesters wait.
- Requests from non-granted requesters are ignored and they see credit_req=0. The arbiter never drops or reorders flits.
- remaining does not wrap: size 0xFFFF is legal and forwards 65535 payload flits.
- Reset (asynchronous, any time, including mid-packet) clears all state:
  - state=IDLE, last=NUMBERPENOC-1 (first grant goes to requester 0)
  - grant=0, busy=0, service_o=0, service_vld=0, remaining=0
  - tx_o=0, data_o=0, credit_req=0
  - A partially forwarded packet is abandoned; recovery is the requester's responsibility.

## Timing

- Grant latency: tx_req seen in IDLE at edge k → grant valid after edge k; the header can transfer at edge k+1.
- Forwarding adds zero cycles (combinational); credit_i→credit_req is also combinational.
- Release:
  - After the last flit transfer at edge m, the FSM is in IDLE during cycle m+1.
  - The next grant registers at edge m+1 and its header can transfer at edge m+2.
  - This gives exactly one bubble cycle between back-to-back packets.
- Throughput: a packet of S payload flits, with credit held high, occupies S+2 transfer cycles plus 1 arbitration cycle.
- Simultaneous events:
  - A request that arrives in the same cycle as a release is not considered until IDLE.
  - Among concurrent requests, round-robin order from last+1 decides.
- service_vld is high for exactly the cycle after the first payload transfer. It is never asserted for size-0 packets.
- grant and busy change only on the rel edge or on reset assertion.

## Test plan

- Single packet: after reset, requester 2 sends header 0x0101, size 0x0003, payload 0x0020/0xAAAA/0xBBBB with credit_i=1 → grant=0100 one cycle later; data_o sequence is 0x0101, 0x0003, 0x0020, 0xAAAA, 0xBBBB over 5 consecutive cycles; service_o=0x0020 with one service_vld pulse; busy falls after the fifth transfer.
- Round-robin fairness: all 4 requesters continuously send 3-flit-payload packets (size 0x0003) → grant order is 0, 1, 2, 3, 0, …, with one idle cycle between packets and each requester served once per rotation.
- Backpressure: credit_i toggles 1,0,0,1 during the payload → transfers occur only on edges with credit_i=1; credit_req[g] mirrors credit_i; the other credit_req bits stay 0; payload order is preserved.
- Boundary sizes:
  - size 0x0000 → only 2 flits are forwarded, grant is released, and service_vld is never asserted.
  - size 0x0001 with payload 0x0070 → service_o=0x0070 and release after 3 flits.
- Requester stall: the granted requester drops tx_req for 10 cycles mid-payload while another requester asserts tx_req → grant is unchanged, tx_o=0, the other requester sees credit_req=0, and the packet completes afterward.
- Reset mid-packet: assert reset=0 during PAYLOAD (asynchronous, off-edge) → tx_o, grant, busy, and credit_req go to 0 immediately; after release, a new request from requester 1 is granted with a fresh header/size sequence.
